// File: rtl/char_ram_writer_if.sv
// -----------------------------------------------------------------------------
// char_ram_writer_if
//
// Purpose:
//   Bundles the two buses of the character memory write engine. The first is the
//   host byte stream (valid/ready handshake). The second is the memory port: the
//   registered write port plus the readback address/data pair.
//
// Signals:
//   s_valid  stream byte valid                      (host   -> writer)
//   s_ready  stream byte accepted when both high    (writer -> host)
//   s_data   stream byte                            (host   -> writer)
//   wr_en    memory write enable                    (writer -> memory)
//   wr_addr  memory write address                   (writer -> memory)
//   wr_data  memory write data                      (writer -> memory)
//   rd_addr  readback address                       (writer -> memory)
//   rd_data  readback data, one cycle after rd_addr (memory -> writer)
//
// Modports:
//   slave   the writer: it sinks the stream and owns the memory port
//   master  the surroundings: the host stream source and the memory
// -----------------------------------------------------------------------------
interface char_ram_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  s_valid, s_data, rd_data,
    output s_ready, wr_en, wr_addr, wr_data, rd_addr
  );

  modport master (
    output s_valid, s_data, rd_data,
    input  s_ready, wr_en, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/char_ram_writer.sv
// -----------------------------------------------------------------------------
// char_ram_writer
//
// Purpose:
//   Write-side engine for the 4096x8 character glyph memory. It accepts a host
//   byte stream and bulk-fill commands, and drives the memory's registered write
//   port. An auto-advancing write pointer with a programmable stride (0..15) lets
//   the host upload fonts and clear or patch glyph rows at run time.
//
// Optional feature (compile-time macro CHAR_WR_VERIFY_EN):
//   When defined, each written byte is read back and compared. rd_addr repeats
//   wr_addr one cycle after the write. The returned rd_data is compared two
//   cycles after the write. A mismatch raises the sticky verify_err. Writing is
//   never stalled. When undefined, rd_addr and verify_err are tied to 0, rd_data
//   is ignored, and no compare pipeline exists.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high; aborts a running fill at once
//   bus         char_ram_writer_if.slave: stream handshake + memory port
//   ptr_load    strobe: load pointer from ptr_value and stride from ptr_incr
//   ptr_value   new pointer value
//   ptr_incr    new stride
//   fill_start  strobe: start a bulk fill of fill_count copies of fill_value
//   fill_value  fill byte, latched on fill_start
//   fill_count  fill length; 0 is a no-op, values above 2**ADDR_W clip
//   err_clr     clears err and verify_err (a same-cycle new error wins)
//   busy        high while a fill is running
//   err         sticky: a command arrived while busy and was dropped
//   ptr         current write pointer
//   verify_err  sticky: readback mismatch
// -----------------------------------------------------------------------------
module char_ram_writer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  char_ram_writer_if.slave  bus,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_value,
  input  logic [3:0]        ptr_incr,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [ADDR_W:0]   fill_count,
  input  logic              err_clr,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] ptr,
  output logic              verify_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Largest fill the pointer space can hold, and the "last write" count.
  localparam logic [ADDR_W:0] MaxFill = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneCnt  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        stride_q, stride_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] fill_value_q, fill_value_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic              s_ready;
  logic              accept;
  logic              fill_req;
  logic              cmd_dropped;
  logic [ADDR_W-1:0] ptr_step;
  logic [ADDR_W:0]   fill_len;

  assign accept   = s_ready && bus.s_valid;
  assign fill_req = fill_start && (fill_count != '0);
  // Modulo-2**ADDR_W advance; the carry out of the top bit is discarded.
  assign ptr_step = ptr_q + {{(ADDR_W-4){1'b0}}, stride_q};
  assign fill_len = (fill_count > MaxFill) ? MaxFill : fill_count;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: every flop takes a non-blocking assignment so that all registers
      // sample the values from before the clock edge, regardless of block order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default at the top of every combinational block guarantees each
    // output is assigned on every path, so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (fill_req) state_d = ST_FILL;
      // Leave FILL in the same cycle that issues the final write.
      ST_FILL: if (remaining_q == OneCnt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      ST_IDLE: s_ready = 1'b1;
      ST_FILL: busy    = 1'b1;
      default: begin
        s_ready = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pointer, stride, fill bookkeeping, write port, error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d        = ptr_q;
    stride_d     = stride_q;
    remaining_d  = remaining_q;
    fill_value_d = fill_value_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cmd_dropped  = 1'b0;

    if (state_q == ST_IDLE) begin
      // The three IDLE actions are applied in order. Later assignments override
      // the pointer, so an accepted byte uses the old ptr. A load then replaces
      // the advanced ptr. A fill starts from whatever ptr results.
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = bus.s_data;
        ptr_d     = ptr_step;
      end
      if (ptr_load) begin
        ptr_d    = ptr_value;
        stride_d = ptr_incr;
      end
      if (fill_req) begin
        remaining_d  = fill_len;
        fill_value_d = fill_value;
      end
    end else begin
      wr_en_d     = 1'b1;
      wr_addr_d   = ptr_q;
      wr_data_d   = fill_value_q;
      ptr_d       = ptr_step;
      remaining_d = remaining_q - OneCnt;
      cmd_dropped = ptr_load || fill_start;
    end

    // A new error takes precedence over a simultaneous clear.
    if (cmd_dropped) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      stride_q     <= 4'd1;
      remaining_q  <= '0;
      fill_value_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      stride_q     <= stride_d;
      remaining_q  <= remaining_d;
      fill_value_q <= fill_value_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign ptr         = ptr_q;
  assign err         = err_q;

  // ---------------------------------------------------------------------------
  // Readback verification
  // ---------------------------------------------------------------------------
`ifdef CHAR_WR_VERIFY_EN
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              chk1_q, chk1_d;
  logic              chk2_q, chk2_d;
  logic [DATA_W-1:0] exp1_q, exp1_d;
  logic [DATA_W-1:0] exp2_q, exp2_d;
  logic              verify_err_q, verify_err_d;
  logic              mismatch;

  // Write in cycle W. The readback address follows in W+1 and the data returns
  // in W+2, where it meets the written byte after two pipeline stages.
  always_comb begin
    rd_addr_d = wr_addr_q;
    chk1_d    = wr_en_q;
    exp1_d    = wr_data_q;
    chk2_d    = chk1_q;
    exp2_d    = exp1_q;
    mismatch  = chk2_q && (bus.rd_data != exp2_q);

    if (mismatch) begin
      verify_err_d = 1'b1;
    end else if (err_clr) begin
      verify_err_d = 1'b0;
    end else begin
      verify_err_d = verify_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q    <= '0;
      chk1_q       <= 1'b0;
      chk2_q       <= 1'b0;
      exp1_q       <= '0;
      exp2_q       <= '0;
      verify_err_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      chk1_q       <= chk1_d;
      chk2_q       <= chk2_d;
      exp1_q       <= exp1_d;
      exp2_q       <= exp2_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign bus.rd_addr = rd_addr_q;
  // The live compare result is OR-ed in so the flag shows in the compare cycle
  // itself, two cycles after the write. The flop keeps it high afterwards.
  assign verify_err  = verify_err_q | mismatch;
`else
  logic unused_rd_data;

  assign bus.rd_addr    = '0;
  assign verify_err     = 1'b0;
  assign unused_rd_data = ^bus.rd_data;
`endif

endmodule
